scurve_multi_channel: RTL

Multi-channel, parametrised S-curve counter for the SDHCAL DAQ threshold scan. It counts injected charge pulses (clk_ext rising edges) and per-channel ASIC trigger falling edges, in either count-efficiency or trigger-efficiency mode, until a programmable pulse total is reached. It then streams the per-channel trigger counts over a valid/ready port. It sits between the trigger input pins and the USB/FIFO readout path, under control of the scan sequencer.

---
 rtl/scurve_pkg.sv | 15 +
 rtl/scurve_edge_sync.sv | 45 ++++
 rtl/scurve_multi_channel.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/scurve_pkg.sv
// Shared types and constants for the S-curve threshold-scan counter.
package scurve_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COUNT   = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_READOUT = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic MODE_COUNT_EFFI = 1'b0;
    localparam logic MODE_TRIG_EFFI  = 1'b1;

endpackage

// File: rtl/scurve_edge_sync.sv
// Multi-flop synchroniser for an asynchronous input, followed by a registered
// level and one-cycle rise/fall pulses aligned with that level.
module scurve_edge_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic Clk,
    input  logic reset_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic level_q, level_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], d};
        level_d = sync_q[SYNC_STAGES-1];
        rise_d  = sync_q[SYNC_STAGES-1] & ~level_q;
        fall_d  = ~sync_q[SYNC_STAGES-1] & level_q;
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            level_q <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/scurve_multi_channel.sv
// Multi-channel S-curve counter: counts injected pulses and per-channel trigger
// edges until a programmed pulse total, then streams masked channel counts.
module scurve_multi_channel
    import scurve_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int CW          = 16,
    parameter int SYNC_STAGES = 2,
    localparam int IW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           Clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic           abort,
    input  logic           mode,
    input  logic [CW-1:0]  cpt_max,
    input  logic [NCH-1:0] ch_mask,
    input  logic           clk_ext,
    input  logic [NCH-1:0] trigger,
    output logic           busy,
    output logic           done,
    output logic [CW-1:0]  pulse_count,
    output logic           rd_valid,
    input  logic           rd_ready,
    output logic [IW-1:0]  rd_chan,
    output logic [CW-1:0]  rd_count,
    output logic           rd_last,
    output state_t         dbg_state
);

    state_t         state_q, state_d;
    logic           mode_q, mode_d;
    logic [CW-1:0]  cpt_max_q, cpt_max_d;
    logic [NCH-1:0] ch_mask_q, ch_mask_d;
    logic [CW-1:0]  pulse_count_q, pulse_count_d;
    logic [CW-1:0]  trig_cnt_q [NCH];
    logic [CW-1:0]  trig_cnt_d [NCH];
    logic [NCH-1:0] hit_q, hit_d;
    logic [IW-1:0]  rd_idx_q, rd_idx_d;
    logic           rd_valid_q, rd_valid_d;

    logic           clk_level, clk_rise, clk_fall;
    logic [NCH-1:0] trig_level_unused, trig_rise_unused, trig_fall;
    logic [NCH-1:0] trig_inc;
    logic           count_en;
    logic [IW-1:0]  first_idx, next_idx;
    logic           has_next;

    scurve_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_clk_sync (
        .Clk     (Clk),
        .reset_n (reset_n),
        .d       (clk_ext),
        .level   (clk_level),
        .rise    (clk_rise),
        .fall    (clk_fall)
    );

    for (genvar g = 0; g < NCH; g++) begin : g_trig
        scurve_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_trig_sync (
            .Clk     (Clk),
            .reset_n (reset_n),
            .d       (trigger[g]),
            .level   (trig_level_unused[g]),
            .rise    (trig_rise_unused[g]),
            .fall    (trig_fall[g])
        );
        // A rise in the same cycle opens a fresh window, so a stale hit flag is ignored.
        assign trig_inc[g] = trig_fall[g] &
                             ((mode_q == MODE_COUNT_EFFI) |
                              ((mode_q == MODE_TRIG_EFFI) & clk_level & (clk_rise | ~hit_q[g])));
    end

    // Lowest masked channel overall, and lowest masked channel above the current index.
    always_comb begin
        first_idx = '0;
        next_idx  = '0;
        has_next  = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_mask_q[i]) begin
                first_idx = IW'(i);
                if (IW'(i) > rd_idx_q) begin
                    next_idx = IW'(i);
                    has_next = 1'b1;
                end
            end
        end
    end

    // Readout handshake: a word moves when rd_valid & rd_ready at a rising Clk edge;
    // rd_chan/rd_count/rd_last are held while rd_valid is high and rd_ready is low.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        cpt_max_d     = cpt_max_q;
        ch_mask_d     = ch_mask_q;
        pulse_count_d = pulse_count_q;
        trig_cnt_d    = trig_cnt_q;
        hit_d         = hit_q;
        rd_idx_d      = rd_idx_q;
        rd_valid_d    = rd_valid_q;
        count_en      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    mode_d        = mode;
                    cpt_max_d     = cpt_max;
                    ch_mask_d     = ch_mask;
                    pulse_count_d = '0;
                    hit_d         = '0;
                    rd_idx_d      = '0;
                    for (int i = 0; i < NCH; i++) trig_cnt_d[i] = '0;
                    state_d = (cpt_max == '0) ? ST_READOUT : ST_COUNT;
                end
            end
            ST_COUNT: begin
                count_en = 1'b1;
                if (pulse_count_q >= cpt_max_q) begin
                    state_d = ST_DRAIN;
                end else if (clk_rise) begin
                    pulse_count_d = pulse_count_q + CW'(1);
                end
            end
            ST_DRAIN: begin
                count_en = 1'b1;
                if (clk_fall) state_d = ST_READOUT;
            end
            ST_READOUT: begin
                if (!rd_valid_q) begin
                    if (ch_mask_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        rd_idx_d   = first_idx;
                        rd_valid_d = 1'b1;
                    end
                end else if (rd_ready) begin
                    if (has_next) begin
                        rd_idx_d = next_idx;
                    end else begin
                        rd_valid_d = 1'b0;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (count_en) begin
            for (int i = 0; i < NCH; i++) begin
                if (clk_rise) hit_d[i] = 1'b0;
                if (trig_inc[i]) begin
                    hit_d[i] = 1'b1;
                    if (trig_cnt_q[i] != '1) trig_cnt_d[i] = trig_cnt_q[i] + CW'(1);
                end
            end
        end

        if (abort) begin
            state_d    = ST_IDLE;
            rd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE_COUNT_EFFI;
            cpt_max_q     <= '0;
            ch_mask_q     <= '0;
            pulse_count_q <= '0;
            hit_q         <= '0;
            rd_idx_q      <= '0;
            rd_valid_q    <= 1'b0;
            for (int i = 0; i < NCH; i++) trig_cnt_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            cpt_max_q     <= cpt_max_d;
            ch_mask_q     <= ch_mask_d;
            pulse_count_q <= pulse_count_d;
            hit_q         <= hit_d;
            rd_idx_q      <= rd_idx_d;
            rd_valid_q    <= rd_valid_d;
            trig_cnt_q    <= trig_cnt_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign pulse_count = pulse_count_q;
    assign rd_valid    = rd_valid_q;
    assign rd_chan     = rd_idx_q;
    assign rd_count    = trig_cnt_q[rd_idx_q];
    assign rd_last     = rd_valid_q & ~has_next;
    assign dbg_state   = state_q;

endmodule
